modexp_sequencer: RTL and testbench
===================================

// Module: modexp_sequencer
// PURPOSE
//  Square-and-multiply sequencer that computes result = base^exponent mod modulus.
//  Sits downstream of the E/C/P shift registers, which supply exponent, base and modulus.
//  Drives the shared modulo_divisor over its start/done handshake and returns the
//  result to the controller on data_out.
// PARAMETERS
//  EW  24  exponent width (reg_e_out)
//  BW  15  base width (reg_c_out)
//  MW   9  modulus/result width (reg_p_out); 2*MW<=32 and BW<=32 required
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   synchronous reset, active-high
//  start             in   1   1-cycle request; operands sampled on this edge
//  base              in   BW  base operand
//  exponent          in   EW  exponent operand
//  modulus           in   MW  modulus operand
//  busy              out  1   high from the cycle after accepted start until done
//  done              out  1   1-cycle pulse, result/err valid
//  err               out  1   modulus==0 flag, valid with done, held until next start
//  result            out  MW  base^exponent mod modulus, held until next start
//  dividend          out  32  to modulo_divisor
//  divisor           out  32  to modulo_divisor, always {0,modulus_q}
//  start_modulo      out  1   1-cycle pulse to modulo_divisor
//  modulo_remainder  in   32  from modulo_divisor
//  modulo_done       in   1   from modulo_divisor
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, start_modulo=0; result, dividend, divisor=0.
//  FSM: IDLE -> REDUCE -> W_RED -> SQ -> W_SQ -> [MUL -> W_MUL] -> NEXT -> ... -> FIN -> IDLE.
//  IDLE: start=1 latches base_q, exp_q, modulus_q, sets bit index i=EW-1 and acc=1.
//   start while busy is ignored, and operands are not re-latched.
//  Special cases at IDLE+start, each with no modulo ops and done on the next cycle:
//   modulus==0 -> err=1, result=0.
//   modulus==1 -> result=0.
//  REDUCE: dividend={0,base_q}, start_modulo pulse -> W_RED.
//   On modulo_done: b_red=remainder[MW-1:0].
//  SQ: dividend=acc*acc (2*MW bits, zero-ext) -> W_SQ; on done acc=remainder.
//   If exp_q[i]=1 -> MUL; else -> NEXT.
//  MUL: dividend=acc*b_red -> W_MUL; on done acc=remainder -> NEXT.
//  NEXT: i==0 -> FIN, else i=i-1 -> SQ.
//  FIN: result=acc, done=1, busy=0 -> IDLE.
//  Fixed op count: exactly 1+EW+popcount(exponent) modulo requests.
//   No leading-zero skipping, so latency is deterministic for a given modulo latency.
//  Handshake rules:
//   start_modulo is high exactly one cycle per request.
//   dividend/divisor are held stable from the pulse until modulo_done is seen.
//   modulo_done is acted on only in W_* states; elsewhere it is ignored.
//   modulo_done in the same cycle as the pulse is not accepted; earliest is the cycle after.
//  Arithmetic: all products are unsigned. acc and b_red are always < modulus, so the product fits 2*MW.
//  exponent==0: only REDUCE runs, then FIN, so result=1 (modulus>1).
//  rst mid-operation: immediate return to IDLE, start_modulo=0.
//   A late modulo_done after reset is ignored.
// TESTING
//  base=4, exponent=13, modulus=497 -> result=445, err=0; exactly 28 start_modulo pulses.
//  base=1000, exponent=1, modulus=7 -> result=6; 26 pulses; first dividend=1000.
//  base=5, exponent=0, modulus=11 -> result=1; modulus=1 -> result=0 with 0 pulses.
//  modulus=0, any operands -> done 1 cycle after start, err=1, result=0, no start_modulo.
//  start re-asserted while busy with new operands -> ignored, first result unchanged.
//   Then rst mid-run -> all outputs at reset values; next run is correct.
//  Randomised modulo latency 1..40 cycles, 200 random operand sets -> result matches the reference model.
//   dividend stays stable during every wait.

Source files
------------

// File: rtl/modexp_sequencer.sv
// Square-and-multiply sequencer: result = base^exponent mod modulus.
// Each modular reduction is delegated to an external modulo_divisor through a
// start/done handshake. The exponent is scanned MSB-first over its full width,
// so the number of reductions depends only on the exponent's popcount.
module modexp_sequencer #(
    parameter int unsigned EW = 24,
    parameter int unsigned BW = 15,
    parameter int unsigned MW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [BW-1:0] base,
    input  logic [EW-1:0] exponent,
    input  logic [MW-1:0] modulus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [MW-1:0] result,
    output logic [31:0]   dividend,
    output logic [31:0]   divisor,
    output logic          start_modulo,
    input  logic [31:0]   modulo_remainder,
    input  logic          modulo_done
);

    localparam int unsigned IW = (EW > 1) ? $clog2(EW) : 1;

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StReduce = 4'd1;
    localparam logic [3:0] StWRed   = 4'd2;
    localparam logic [3:0] StSq     = 4'd3;
    localparam logic [3:0] StWSq    = 4'd4;
    localparam logic [3:0] StMul    = 4'd5;
    localparam logic [3:0] StWMul   = 4'd6;
    localparam logic [3:0] StNext   = 4'd7;
    localparam logic [3:0] StFin    = 4'd8;

    logic [3:0]      state;
    logic [BW-1:0]   base_q;
    logic [EW-1:0]   exp_q;
    logic [MW-1:0]   modulus_q;
    logic [IW-1:0]   idx;
    logic [MW-1:0]   acc;
    logic [MW-1:0]   b_red;
    logic [2*MW-1:0] prod;
    logic            rem_valid;
    logic            unused_rem_hi;

    // Only the low MW bits of a remainder can be non-zero since it is < modulus.
    assign unused_rem_hi = ^modulo_remainder[31:MW];

    // Squaring in SQ, multiply by the reduced base otherwise; acc, b_red < modulus.
    always_comb begin
        if (state == StSq) begin
            prod = {{MW{1'b0}}, acc} * {{MW{1'b0}}, acc};
        end else begin
            prod = {{MW{1'b0}}, acc} * {{MW{1'b0}}, b_red};
        end
    end

    // A done arriving while our own request pulse is still high is too early.
    assign rem_valid = modulo_done && !start_modulo;

    // Sequencer state, operand registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            start_modulo <= 1'b0;
            result       <= '0;
            dividend     <= '0;
            divisor      <= '0;
            base_q       <= '0;
            exp_q        <= '0;
            modulus_q    <= '0;
            idx          <= '0;
            acc          <= '0;
            b_red        <= '0;
        end else begin
            start_modulo <= 1'b0;
            done         <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        base_q    <= base;
                        exp_q     <= exponent;
                        modulus_q <= modulus;
                        divisor   <= 32'(modulus);
                        idx       <= IW'(EW - 1);
                        acc       <= MW'(1);
                        err       <= (modulus == '0);
                        if (modulus <= MW'(1)) begin
                            // Trivial moduli: answer is 0 without any reductions.
                            result <= '0;
                            done   <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= StReduce;
                        end
                    end
                end
                StReduce: begin
                    dividend     <= 32'(base_q);
                    start_modulo <= 1'b1;
                    state        <= StWRed;
                end
                StWRed: begin
                    if (rem_valid) begin
                        b_red <= modulo_remainder[MW-1:0];
                        state <= (exp_q == '0) ? StFin : StSq;
                    end
                end
                StSq: begin
                    dividend     <= 32'(prod);
                    start_modulo <= 1'b1;
                    state        <= StWSq;
                end
                StWSq: begin
                    if (rem_valid) begin
                        acc   <= modulo_remainder[MW-1:0];
                        state <= exp_q[idx] ? StMul : StNext;
                    end
                end
                StMul: begin
                    dividend     <= 32'(prod);
                    start_modulo <= 1'b1;
                    state        <= StWMul;
                end
                StWMul: begin
                    if (rem_valid) begin
                        acc   <= modulo_remainder[MW-1:0];
                        state <= StNext;
                    end
                end
                StNext: begin
                    if (idx == '0) begin
                        state <= StFin;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= StSq;
                    end
                end
                StFin: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: behavioural modulo_divisor with variable latency,
// directed corner cases and randomized operands against a reference model.
module tb_modexp_sequencer;

    localparam int unsigned EW = 24;
    localparam int unsigned BW = 15;
    localparam int unsigned MW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] base;
    logic [EW-1:0] exponent;
    logic [MW-1:0] modulus;
    logic          busy;
    logic          done;
    logic          err;
    logic [MW-1:0] result;
    logic [31:0]   dividend;
    logic [31:0]   divisor;
    logic          start_modulo;
    logic [31:0]   modulo_remainder;
    logic          modulo_done;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    logic [31:0] first_div;
    bit  drv_busy = 1'b0;
    int  lat_mode = 0;

    modexp_sequencer #(.EW(EW), .BW(BW), .MW(MW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .base             (base),
        .exponent         (exponent),
        .modulus          (modulus),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .result           (result),
        .dividend         (dividend),
        .divisor          (divisor),
        .start_modulo     (start_modulo),
        .modulo_remainder (modulo_remainder),
        .modulo_done      (modulo_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // LSB-first binary exponentiation with wide integers.
    function automatic int unsigned ref_modexp(input int unsigned b, input int unsigned e,
                                               input int unsigned m);
        longint unsigned r, x;
        int unsigned     ee;
        if (m <= 1) return 0;
        r  = 1;
        x  = longint'(b) % longint'(m);
        ee = e;
        while (ee != 0) begin
            if (ee[0]) r = (r * x) % longint'(m);
            x  = (x * x) % longint'(m);
            ee = ee >> 1;
        end
        return int'(r);
    endfunction

    function automatic int ref_pulses(input int unsigned e, input int unsigned m);
        if (m <= 1) return 0;
        if (e == 0) return 1;
        return 1 + EW + $countones(e);
    endfunction

    // Behavioural modulo_divisor: answers each request after a chosen latency.
    initial begin
        logic [31:0] cap_div, cap_dsr;
        int          lat;
        bit          aborted;
        modulo_done      = 1'b0;
        modulo_remainder = '0;
        forever begin
            @(posedge clk); #1;
            if (start_modulo === 1'b1 && rst !== 1'b1) begin
                drv_busy = 1'b1;
                pulses++;
                if (pulses == 1) first_div = dividend;
                cap_div = dividend;
                cap_dsr = divisor;
                aborted = 1'b0;
                if (lat_mode == 0) lat = 3;
                else if ($urandom_range(0, 7) == 0) lat = $urandom_range(1, 40);
                else lat = $urandom_range(1, 4);
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk); #1;
                    if (rst === 1'b1) aborted = 1'b1;
                    if (!aborted) begin
                        chk("dividend_stable", dividend, cap_div);
                        chk("divisor_stable", divisor, cap_dsr);
                        chk("pulse_one_cycle", 32'(start_modulo), 32'd0);
                    end
                end
                modulo_remainder = (cap_dsr == 0) ? 32'd0 : cap_div % cap_dsr;
                modulo_done      = 1'b1;
                @(posedge clk); #1;
                modulo_done = 1'b0;
                drv_busy    = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (drv_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (drv_busy) chk("driver_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_start(input int unsigned b, input int unsigned e, input int unsigned m);
        start    = 1'b1;
        base     = BW'(b);
        exponent = EW'(e);
        modulus  = MW'(m);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_check(input int unsigned b, input int unsigned e, input int unsigned m);
        bit got;
        wait_idle();
        pulses = 0;
        do_start(b, e, m);
        if (m <= 1) chk("special_done_next_cycle", 32'(done), 32'd1);
        else chk("busy_after_start", 32'(busy), 32'd1);
        wait_done(got);
        if (got) begin
            chk("result", 32'(result), ref_modexp(b, e, m));
            chk("err", 32'(err), (m == 0) ? 32'd1 : 32'd0);
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("pulse_count", pulses, ref_pulses(e, m));
            @(posedge clk); #1;
            chk("done_one_cycle", 32'(done), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_start_modulo", 32'(start_modulo), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_dividend", dividend, 32'd0);
        chk("rst_divisor", divisor, 32'd0);
    endtask

    initial begin
        bit got;
        rst      = 1'b1;
        start    = 1'b0;
        base     = '0;
        exponent = '0;
        modulus  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        run_check(4, 13, 497);
        chk("ex1_result", 32'(result), 32'd445);
        chk("ex1_pulses", pulses, 32'd28);

        run_check(1000, 1, 7);
        chk("ex2_result", 32'(result), 32'd6);
        chk("ex2_pulses", pulses, 32'd26);
        chk("ex2_first_dividend", first_div, 32'd1000);

        run_check(5, 0, 11);
        chk("exp0_result", 32'(result), 32'd1);

        run_check(5, 13, 1);
        chk("mod1_pulses", pulses, 32'd0);

        run_check(9, 3, 0);
        chk("mod0_err", 32'(err), 32'd1);
        chk("mod0_pulses", pulses, 32'd0);

        // New start with different operands while busy must be ignored.
        wait_idle();
        pulses = 0;
        do_start(4, 13, 497);
        repeat (5) @(posedge clk);
        #1;
        do_start(7, 5, 11);
        wait_done(got);
        chk("busy_start_result", 32'(result), 32'd445);
        chk("busy_start_pulses", pulses, 32'd28);
        chk("busy_start_divisor", divisor, 32'd497);
        @(posedge clk); #1;

        // Reset in the middle of a run, then a clean run afterwards.
        wait_idle();
        do_start(4, 13, 497);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_check(3, 200, 1019 % 512);

        lat_mode = 1;
        for (int n = 0; n < 200; n++) begin
            int unsigned b, e, m;
            b = $urandom_range(0, 32767);
            e = $urandom_range(0, 32'hFF_FFFF);
            if (n % 25 == 0) m = $urandom_range(0, 1);
            else m = $urandom_range(2, 511);
            run_check(b, e, m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
